cache_ctrl_fsm: RTL and testbench

//  Sequencing controller for the 4-way, 128-set, 64-byte-line write-back cache array. Accepts
//  one CPU load/store at a time and drives the array's lookup, victim-read and allocate ports.

---
 rtl/cache_ctrl_fsm.sv | 204 ++++++++++++++++++++
 tb/tb_cache_ctrl_fsm.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl_fsm.sv
// Sequencing controller for a 4-way write-back cache array: lookup, dirty-victim
// writeback, line fill, allocate and replay of a single outstanding CPU access.
module cache_ctrl_fsm #(
  parameter int unsigned TAG_W  = 19,
  parameter int unsigned SET_W  = 7,
  parameter int unsigned LINE_W = 512,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_done,
  output logic [31:0]       cpu_rdata,
  output logic              busy,
  output logic              ca_read_enable,
  output logic              ca_write_enable,
  output logic [31:0]       ca_addr,
  output logic [31:0]       ca_write_data,
  input  logic [31:0]       ca_read_data,
  input  logic              ca_hit,
  input  logic              ca_evict_dirty,
  input  logic [TAG_W-1:0]  ca_evict_tag,
  input  logic [SET_W-1:0]  ca_evict_set,
  input  logic [LINE_W-1:0] ca_evict_data,
  output logic              ca_alloc_enable,
  output logic [31:0]       ca_alloc_addr,
  output logic [LINE_W-1:0] ca_alloc_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned OFF_W  = ADDR_W - TAG_W - SET_W;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_CHECK, S_WB, S_FILL, S_ALLOC, S_RESP
  } state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                replay_q, replay_d;
  logic [TAG_W-1:0]    evict_tag_q, evict_tag_d;
  logic [SET_W-1:0]    evict_set_q, evict_set_d;
  logic [LINE_W-1:0]   victim_q, victim_d;
  logic [LINE_W-1:0]   fill_q, fill_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [CNT_W-1:0]    hit_q, hit_d;
  logic [CNT_W-1:0]    miss_q, miss_d;
  logic                cpu_done_q, cpu_done_d;
  logic                busy_q, busy_d;
  logic                rd_en_q, rd_en_d;
  logic                wr_en_q, wr_en_d;
  logic                alloc_en_q, alloc_en_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;

  // State, request copy, line buffers, counters and registered strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      replay_q    <= 1'b0;
      evict_tag_q <= '0;
      evict_set_q <= '0;
      victim_q    <= '0;
      fill_q      <= '0;
      rdata_q     <= '0;
      hit_q       <= '0;
      miss_q      <= '0;
      cpu_done_q  <= 1'b0;
      busy_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      alloc_en_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      replay_q    <= replay_d;
      evict_tag_q <= evict_tag_d;
      evict_set_q <= evict_set_d;
      victim_q    <= victim_d;
      fill_q      <= fill_d;
      rdata_q     <= rdata_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      cpu_done_q  <= cpu_done_d;
      busy_q      <= busy_d;
      rd_en_q     <= rd_en_d;
      wr_en_q     <= wr_en_d;
      alloc_en_q  <= alloc_en_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
    end
  end

  // Next state, latched data, and output strobes decoded from the next state
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    replay_d    = replay_q;
    evict_tag_d = evict_tag_q;
    evict_set_d = evict_set_q;
    victim_d    = victim_q;
    fill_d      = fill_q;
    rdata_d     = rdata_q;
    hit_d       = hit_q;
    miss_d      = miss_q;

    unique case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          we_d     = cpu_we;
          addr_d   = cpu_addr;
          wdata_d  = cpu_wdata;
          replay_d = 1'b0;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_CHECK;
      S_CHECK: begin
        if (ca_hit) begin
          if (!we_q)     rdata_d = ca_read_data;
          if (!replay_q) hit_d   = hit_q + CNT_W'(1);
          state_d = S_RESP;
        end else begin
          // A replay miss re-enters the miss path but is not counted again
          if (!replay_q) miss_d = miss_q + CNT_W'(1);
          evict_tag_d = ca_evict_tag;
          evict_set_d = ca_evict_set;
          victim_d    = ca_evict_data;
          state_d     = ca_evict_dirty ? S_WB : S_FILL;
        end
      end
      S_WB: begin
        if (mem_ready) state_d = S_FILL;
      end
      S_FILL: begin
        if (mem_ready) begin
          fill_d  = mem_rdata;
          state_d = S_ALLOC;
        end
      end
      S_ALLOC: begin
        replay_d = 1'b1;
        state_d  = S_ISSUE;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d     = (state_d != S_IDLE);
    cpu_done_d = (state_d == S_RESP);
    rd_en_d    = (state_d == S_ISSUE) && !we_d;
    wr_en_d    = (state_d == S_ISSUE) &&  we_d;
    alloc_en_d = (state_d == S_ALLOC);
    mem_req_d  = (state_d == S_WB) || (state_d == S_FILL);
    mem_we_d   = (state_d == S_WB);
    mem_addr_d = '0;
    if (state_d == S_WB)
      mem_addr_d = {evict_tag_d, evict_set_d, OFF_W'(0)};
    else if (state_d == S_FILL)
      mem_addr_d = {addr_d[ADDR_W-1:OFF_W], OFF_W'(0)};
  end

  assign cpu_done        = cpu_done_q;
  assign cpu_rdata       = rdata_q;
  assign busy            = busy_q;
  assign ca_read_enable  = rd_en_q;
  assign ca_write_enable = wr_en_q;
  assign ca_addr         = addr_q;
  assign ca_write_data   = wdata_q;
  assign ca_alloc_enable = alloc_en_q;
  assign ca_alloc_addr   = {addr_q[ADDR_W-1:OFF_W], OFF_W'(0)};
  assign ca_alloc_data   = fill_q;
  assign mem_req         = mem_req_q;
  assign mem_we          = mem_we_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wdata       = victim_q;
  assign hit_count       = hit_q;
  assign miss_count      = miss_q;

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Bench for cache_ctrl_fsm: behavioural 4-way cache array and line memory around the
// controller, with queued expectations for CPU responses and memory transactions.
module tb_cache_ctrl_fsm;
  localparam int unsigned TAG_W  = 19;
  localparam int unsigned SET_W  = 7;
  localparam int unsigned LINE_W = 512;
  localparam int unsigned CNT_W  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic cpu_done, busy;
  logic [31:0] cpu_rdata;
  logic ca_read_enable, ca_write_enable, ca_alloc_enable;
  logic [31:0] ca_addr, ca_write_data, ca_alloc_addr;
  logic [31:0] ca_read_data = '0;
  logic ca_hit = 1'b0, ca_evict_dirty = 1'b0;
  logic [TAG_W-1:0] ca_evict_tag = '0;
  logic [SET_W-1:0] ca_evict_set = '0;
  logic [LINE_W-1:0] ca_evict_data = '0;
  logic [LINE_W-1:0] ca_alloc_data;
  logic mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata = '0;
  logic mem_ready = 1'b0;
  logic [CNT_W-1:0] hit_count, miss_count;

  cache_ctrl_fsm dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .busy(busy),
    .ca_read_enable(ca_read_enable), .ca_write_enable(ca_write_enable),
    .ca_addr(ca_addr), .ca_write_data(ca_write_data), .ca_read_data(ca_read_data),
    .ca_hit(ca_hit), .ca_evict_dirty(ca_evict_dirty), .ca_evict_tag(ca_evict_tag),
    .ca_evict_set(ca_evict_set), .ca_evict_data(ca_evict_data),
    .ca_alloc_enable(ca_alloc_enable), .ca_alloc_addr(ca_alloc_addr),
    .ca_alloc_data(ca_alloc_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              we;
    logic [31:0]       addr;
    logic [LINE_W-1:0] data;
  } mop_t;

  mop_t exp_mq[$];
  mop_t obs_q[$];
  logic [31:0] rsp_q[$];
  int lat_q[$];

  int checks = 0, failures = 0;
  int exp_hits = 0, exp_misses = 0;
  int wb_delay = 0, fill_delay = 0;
  int unstable_cnt = 0;
  logic [31:0] last_rd = '0;
  logic [31:0] ref_words [logic [31:0]];
  logic [LINE_W-1:0] mem_model [logic [31:0]];

  function automatic logic [31:0] def_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [LINE_W-1:0] def_line(input logic [31:0] base);
    logic [LINE_W-1:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = def_word(base + 32'(i * 4));
    return l;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] k;
    k = {a[31:2], 2'b00};
    return ref_words.exists(k) ? ref_words[k] : def_word(k);
  endfunction

  function automatic logic [LINE_W-1:0] ref_line(input logic [31:0] base);
    logic [LINE_W-1:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = ref_word(base + 32'(i * 4));
    return l;
  endfunction

  // Cache array: registered lookup result, invalid-first then round-robin victim
  logic [TAG_W-1:0]  a_tag   [128][4];
  logic [LINE_W-1:0] a_data  [128][4];
  bit                a_valid [128][4];
  bit                a_dirty [128][4];
  int unsigned       a_rr    [128];
  int                a_vway = 0;

  always @(posedge clk) begin : array_model
    int s, w, hw, v;
    if (ca_read_enable || ca_write_enable) begin
      s = int'(ca_addr[12:6]);
      w = int'(ca_addr[5:2]);
      hw = -1;
      for (int i = 0; i < 4; i++)
        if (a_valid[s][i] && a_tag[s][i] == ca_addr[31:13]) hw = i;
      if (hw >= 0) begin
        ca_hit <= 1'b1;
        ca_read_data <= a_data[s][hw][w*32 +: 32];
        if (ca_write_enable) begin
          a_data[s][hw][w*32 +: 32] = ca_write_data;
          a_dirty[s][hw] = 1'b1;
        end
      end else begin
        v = -1;
        for (int i = 3; i >= 0; i--) if (!a_valid[s][i]) v = i;
        if (v < 0) v = int'(a_rr[s]);
        a_vway = v;
        ca_hit <= 1'b0;
        ca_evict_dirty <= a_valid[s][v] && a_dirty[s][v];
        ca_evict_tag <= a_tag[s][v];
        ca_evict_set <= SET_W'(s);
        ca_evict_data <= a_data[s][v];
      end
    end
    if (ca_alloc_enable) begin
      s = int'(ca_alloc_addr[12:6]);
      if (a_valid[s][a_vway]) a_rr[s] = (a_rr[s] + 1) % 4;
      a_tag[s][a_vway]   = ca_alloc_addr[31:13];
      a_data[s][a_vway]  = ca_alloc_data;
      a_valid[s][a_vway] = 1'b1;
      a_dirty[s][a_vway] = 1'b0;
    end
  end

  // Memory responder: ready after a per-direction delay; records every handshake
  always @(negedge clk) begin : mem_model_p
    int wait_cnt;
    logic [31:0] hold_addr;
    logic hold_we;
    mop_t o;
    if (mem_ready) wait_cnt = 0;
    if (mem_req === 1'b1) begin
      if (wait_cnt != 0 && (mem_addr !== hold_addr || mem_we !== hold_we)) unstable_cnt++;
      hold_addr = mem_addr;
      hold_we   = mem_we;
      if (wait_cnt >= (mem_we ? wb_delay : fill_delay)) begin
        mem_ready = 1'b1;
        o.we = mem_we; o.addr = mem_addr; o.data = mem_we ? mem_wdata : '0;
        obs_q.push_back(o);
        if (mem_we) mem_model[mem_addr] = mem_wdata;
        else mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : def_line(mem_addr);
      end else begin
        mem_ready = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem_ready = 1'b0;
      wait_cnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic expect_mem(input logic we, input logic [31:0] addr);
    mop_t e;
    e.we = we; e.addr = addr; e.data = we ? ref_line(addr) : '0;
    exp_mq.push_back(e);
  endtask

  task automatic check_mem(input string tag);
    mop_t e, o;
    chk({tag, ":mem_ops"}, LINE_W'(obs_q.size()), LINE_W'(exp_mq.size()));
    while (exp_mq.size() > 0 && obs_q.size() > 0) begin
      e = exp_mq.pop_front();
      o = obs_q.pop_front();
      chk({tag, ":mem_we"}, LINE_W'(o.we), LINE_W'(e.we));
      chk({tag, ":mem_addr"}, LINE_W'(o.addr), LINE_W'(e.addr));
      if (e.we) chk({tag, ":mem_wdata"}, o.data, e.data);
    end
    exp_mq.delete();
    obs_q.delete();
  endtask

  // One CPU access; the request fields are scrambled once accepted
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input bit hit, input int exp_lat, input string tag);
    int lat;
    bit seen;
    if (we) ref_words[{addr[31:2], 2'b00}] = wdata;
    else last_rd = ref_word(addr);
    rsp_q.push_back(last_rd);
    lat_q.push_back(exp_lat);
    if (hit) exp_hits++; else exp_misses++;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 300) begin
      @(posedge clk);
      lat++;
      #1;
      cpu_we = ~we; cpu_addr = ~addr; cpu_wdata = ~wdata;
      @(negedge clk);
      seen = (cpu_done === 1'b1);
    end
    cpu_req = 1'b0;
    chk({tag, ":done"}, LINE_W'(seen), LINE_W'(1));
    chk({tag, ":rdata"}, LINE_W'(cpu_rdata), LINE_W'(rsp_q.pop_front()));
    chk({tag, ":latency"}, LINE_W'(lat), LINE_W'(lat_q.pop_front()));
    chk({tag, ":hit_count"}, LINE_W'(hit_count), LINE_W'(exp_hits));
    chk({tag, ":miss_count"}, LINE_W'(miss_count), LINE_W'(exp_misses));
    check_mem(tag);
    @(negedge clk);
    chk({tag, ":idle"}, LINE_W'({busy, cpu_done}), LINE_W'(0));
  endtask

  initial begin
    bit seen;
    repeat (2) @(negedge clk);
    chk("reset:busy", LINE_W'(busy), LINE_W'(0));
    chk("reset:outputs", LINE_W'({cpu_done, mem_req, ca_read_enable, ca_write_enable, ca_alloc_enable}), LINE_W'(0));
    chk("reset:counts", LINE_W'({hit_count, miss_count}), LINE_W'(0));
    chk("reset:rdata", LINE_W'(cpu_rdata), LINE_W'(0));
    rst = 1'b0;
    @(negedge clk);

    expect_mem(1'b0, 32'h0000_1040);
    access(1'b0, 32'h0000_1040, 32'h0, 1'b0, 7, "cold_load");
    access(1'b0, 32'h0000_1044, 32'h0, 1'b1, 3, "hit_load");
    access(1'b1, 32'h0000_1048, 32'hDEAD_BEEF, 1'b1, 3, "store_hit");
    access(1'b0, 32'h0000_1048, 32'h0, 1'b1, 3, "load_back");

    // Fill set 1 with four tags, dirty way 0, then a fifth tag evicts it
    expect_mem(1'b0, 32'h0000_2040);
    access(1'b0, 32'h0000_2040, 32'h0, 1'b0, 7, "set1_a");
    access(1'b1, 32'h0000_2048, 32'hCAFE_0001, 1'b1, 3, "set1_dirty");
    expect_mem(1'b0, 32'h0000_4040);
    access(1'b0, 32'h0000_4040, 32'h0, 1'b0, 7, "set1_b");
    expect_mem(1'b0, 32'h0000_6040);
    access(1'b0, 32'h0000_6040, 32'h0, 1'b0, 7, "set1_c");
    expect_mem(1'b0, 32'h0000_8040);
    access(1'b0, 32'h0000_8040, 32'h0, 1'b0, 7, "set1_d");
    expect_mem(1'b1, 32'h0000_2040);
    expect_mem(1'b0, 32'h0000_A040);
    access(1'b0, 32'h0000_A040, 32'h0, 1'b0, 8, "set1_evict");

    fill_delay = 10;
    expect_mem(1'b0, 32'h0000_C080);
    access(1'b0, 32'h0000_C080, 32'h0, 1'b0, 17, "slow_fill");
    chk("slow_fill:stable", LINE_W'(unstable_cnt), LINE_W'(0));
    fill_delay = 0;

    expect_mem(1'b0, 32'h0000_E0C0);
    access(1'b1, 32'h0000_E0C0, 32'h1234_5678, 1'b0, 7, "store_miss");
    access(1'b0, 32'h0000_E0C0, 32'h0, 1'b1, 3, "store_miss_back");

    // Dirty way 1 of set 1, then reset while its writeback is pending
    access(1'b1, 32'h0000_4044, 32'h0BAD_F00D, 1'b1, 3, "set1_dirty_b");
    wb_delay = 5;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_C040; cpu_wdata = '0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = (mem_req === 1'b1 && mem_we === 1'b1);
    end
    chk("rst_wb:reached", LINE_W'(seen), LINE_W'(1));
    chk("rst_wb:addr", LINE_W'(mem_addr), LINE_W'(32'h0000_4040));
    #2 rst = 1'b1;
    #1;
    chk("rst_wb:mem_req", LINE_W'(mem_req), LINE_W'(0));
    chk("rst_wb:busy", LINE_W'(busy), LINE_W'(0));
    chk("rst_wb:counts", LINE_W'({hit_count, miss_count}), LINE_W'(0));
    chk("rst_wb:rdata", LINE_W'(cpu_rdata), LINE_W'(0));
    @(negedge clk);
    rst = 1'b0; cpu_req = 1'b0; wb_delay = 0;
    chk("rst_wb:no_mem_op", LINE_W'(obs_q.size()), LINE_W'(0));
    exp_mq.delete(); obs_q.delete();
    exp_hits = 0; exp_misses = 0; last_rd = '0;
    @(negedge clk);
    access(1'b0, 32'h0000_1048, 32'h0, 1'b1, 3, "post_rst_load");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
